messbauer_channel_monitor: RTL and testbench

MESSBAUER_CHANNEL_MONITOR -- requirements
Module: messbauer_channel_monitor

---
 rtl/messbauer_pkg.sv | 22 ++
 rtl/messbauer_edge_detector.sv | 19 +
 rtl/messbauer_channel_monitor.sv | 117 +++++++++++
 tb/tb_messbauer_channel_monitor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/messbauer_pkg.sv
// Shared Messbauer definitions: monitor state encoding, error flag bit positions, widths.
// Later spectrum-accumulation stages import the same package.
package messbauer_pkg;

  localparam int IDX_W       = 10;
  localparam int FRAME_CNT_W = 16;
  localparam int TMO_W       = 24;
  localparam int ERR_W       = 4;

  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mon_state_t;

  localparam int ERR_MISSING  = 0;
  localparam int ERR_EXTRA    = 1;
  localparam int ERR_OVERFLOW = 2;
  localparam int ERR_TIMEOUT  = 3;

endpackage

// File: rtl/messbauer_edge_detector.sv
// Rising-edge detector: one registered history bit, rise = in & ~previous in.
// A level held high produces a single-cycle rise.
module messbauer_edge_detector (
  input  logic aclk,
  input  logic areset_n,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) in_q <= 1'b0;
    else           in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/messbauer_channel_monitor.sv
// Monitors the Messbauer drive generator: counts channel pulses per frame, checks
// frame length on each start pulse, and flags timeouts, overflow and length errors.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for a start edge; channel edges ignored
//   ST_RUN  | counting channel edges; start edge closes and reopens frame
module messbauer_channel_monitor
  import messbauer_pkg::*;
#(
  parameter int CHANNEL_NUMBER = 512,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  input  logic                   start,
  input  logic                   channel,
  input  logic                   clear_errors,
  output logic [IDX_W-1:0]       channel_index,
  output logic                   frame_done,
  output logic                   frame_ok,
  output logic [IDX_W-1:0]       last_channel_count,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [ERR_W-1:0]       error_flags
);

  localparam logic [IDX_W-1:0] CHAN_NUM = IDX_W'(CHANNEL_NUMBER);
  // Down-counter reloads to TIMEOUT_CYCLES-1 on any edge; terminal count 0 means
  // TIMEOUT_CYCLES quiet cycles have elapsed since that edge.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  mon_state_t       state, state_nxt;
  logic             start_rise, chan_rise;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [ERR_W-1:0] err_set;
  logic             frame_close, timeout_hit;

  messbauer_edge_detector u_start_edge (
    .aclk     (aclk),
    .areset_n (areset_n),
    .in       (start),
    .rise     (start_rise)
  );

  messbauer_edge_detector u_chan_edge (
    .aclk     (aclk),
    .areset_n (areset_n),
    .in       (channel),
    .rise     (chan_rise)
  );

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_IDLE) begin
      if (start_rise) state_nxt = ST_RUN;
    end else if (!start_rise && !chan_rise && tmo_cnt == '0) begin
      state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    frame_close = 1'b0;
    timeout_hit = (state == ST_RUN) && (state_nxt == ST_IDLE);
    idx_nxt     = channel_index;
    err_set     = '0;
    tmo_nxt     = tmo_cnt;

    if (start_rise || chan_rise)                tmo_nxt = TMO_LOAD;
    else if (state == ST_RUN && tmo_cnt != '0) tmo_nxt = tmo_cnt - 1'b1;

    if (state == ST_IDLE) begin
      if (start_rise) idx_nxt = {{(IDX_W-1){1'b0}}, chan_rise};
    end else if (start_rise) begin
      // A channel edge coinciding with start belongs to the new frame.
      frame_close = 1'b1;
      idx_nxt     = {{(IDX_W-1){1'b0}}, chan_rise};
      err_set[ERR_MISSING] = (channel_index < CHAN_NUM);
      err_set[ERR_EXTRA]   = (channel_index > CHAN_NUM);
    end else if (chan_rise) begin
      if (channel_index == IDX_MAX) err_set[ERR_OVERFLOW] = 1'b1;
      else                          idx_nxt = channel_index + 1'b1;
    end else if (timeout_hit) begin
      idx_nxt              = '0;
      err_set[ERR_TIMEOUT] = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      channel_index      <= '0;
      tmo_cnt            <= '0;
      frame_done         <= 1'b0;
      frame_ok           <= 1'b0;
      last_channel_count <= '0;
      frame_count        <= '0;
      error_flags        <= '0;
    end else begin
      channel_index <= idx_nxt;
      tmo_cnt       <= tmo_nxt;
      frame_done    <= frame_close;
      if (frame_close) begin
        last_channel_count <= channel_index;
        frame_ok           <= (channel_index == CHAN_NUM);
        frame_count        <= frame_count + 1'b1;
      end
      // New errors are OR-ed after the clear so they survive a same-cycle clear.
      error_flags <= (clear_errors ? '0 : error_flags) | err_set;
    end
  end

endmodule

// File: tb/tb_messbauer_channel_monitor.sv
// Self-checking bench for messbauer_channel_monitor: frame-length vector table,
// hand-written corner sequences, and randomized traffic against a reference model.
module tb_messbauer_channel_monitor;

  localparam int N_CH = 512;
  localparam int TMO  = 100;

  logic        aclk = 1'b0;
  logic        areset_n = 1'b0;
  logic        start = 1'b0, channel = 1'b0, clear_errors = 1'b0;
  logic [9:0]  channel_index, last_channel_count;
  logic        frame_done, frame_ok;
  logic [15:0] frame_count;
  logic [3:0]  error_flags;

  int checks = 0;
  int errors = 0;

  messbauer_channel_monitor #(.CHANNEL_NUMBER(N_CH), .TIMEOUT_CYCLES(TMO)) dut (
    .aclk               (aclk),
    .areset_n           (areset_n),
    .start              (start),
    .channel            (channel),
    .clear_errors       (clear_errors),
    .channel_index      (channel_index),
    .frame_done         (frame_done),
    .frame_ok           (frame_ok),
    .last_channel_count (last_channel_count),
    .frame_count        (frame_count),
    .error_flags        (error_flags)
  );

  always #5 aclk = ~aclk;

  // Reference model, expressed as frame bookkeeping in plain integers.
  bit       m_prev_s, m_prev_c, m_run, m_done, m_ok;
  int       m_idx, m_quiet, m_last, m_fc;
  bit [3:0] m_flags;
  int       cyc = 0;

  task automatic model_reset();
    m_prev_s = 0; m_prev_c = 0; m_run = 0; m_done = 0; m_ok = 0;
    m_idx = 0; m_quiet = 0; m_last = 0; m_fc = 0; m_flags = '0;
  endtask

  task automatic model_step(input bit s, input bit c, input bit clr);
    bit s_rise, c_rise;
    bit [3:0] new_err;
    s_rise = s && !m_prev_s;
    c_rise = c && !m_prev_c;
    m_prev_s = s; m_prev_c = c;
    m_done = 0; new_err = '0;
    if (!m_run) begin
      if (s_rise) begin m_run = 1; m_idx = c_rise ? 1 : 0; m_quiet = 0; end
    end else if (s_rise) begin
      m_last = m_idx; m_done = 1; m_ok = (m_idx == N_CH);
      m_fc = (m_fc + 1) % 65536;
      if (m_idx < N_CH) new_err[0] = 1;
      if (m_idx > N_CH) new_err[1] = 1;
      m_idx = c_rise ? 1 : 0; m_quiet = 0;
    end else if (c_rise) begin
      if (m_idx == 1023) new_err[2] = 1; else m_idx++;
      m_quiet = 0;
    end else begin
      m_quiet++;
      if (m_quiet == TMO) begin new_err[3] = 1; m_run = 0; m_idx = 0; end
    end
    m_flags = (clr ? 4'b0000 : m_flags) | new_err;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic compare_model();
    logic [47:0] act, exp;
    act = {channel_index, frame_done, frame_ok, last_channel_count, frame_count, error_flags};
    exp = {10'(m_idx), m_done, m_ok, 10'(m_last), 16'(m_fc), m_flags};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model cycle %0d: got idx=%0d done=%0b ok=%0b last=%0d fc=%0d flags=%b expected idx=%0d done=%0b ok=%0b last=%0d fc=%0d flags=%b",
               cyc, channel_index, frame_done, frame_ok, last_channel_count, frame_count, error_flags,
               m_idx, m_done, m_ok, m_last, m_fc, m_flags);
    end
  endtask

  task automatic step(input bit s, input bit c, input bit clr);
    start = s; channel = c; clear_errors = clr;
    @(posedge aclk);
    model_step(s, c, clr);
    cyc++;
    #1;
    compare_model();
  endtask

  task automatic send_chans(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0);
      step(0, 0, 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_idx"},   int'(channel_index), 0);
    chk({tag, "_done"},  int'(frame_done), 0);
    chk({tag, "_ok"},    int'(frame_ok), 0);
    chk({tag, "_last"},  int'(last_channel_count), 0);
    chk({tag, "_fc"},    int'(frame_count), 0);
    chk({tag, "_flags"}, int'(error_flags), 0);
  endtask

  typedef struct {
    int       n_chan;
    int       exp_idx;
    int       exp_last;
    bit       exp_ok;
    bit [3:0] exp_flags;
    int       exp_fc;
    bit       clr_after;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{512,  512,  512, 1'b1, 4'b0000, 1, 1'b0};
    vecs[1] = '{510,  510,  510, 1'b0, 4'b0001, 2, 1'b0};
    vecs[2] = '{515,  515,  515, 1'b0, 4'b0011, 3, 1'b1};
    vecs[3] = '{1030, 1023, 1023, 1'b0, 4'b0110, 4, 1'b1};
    vecs[4] = '{512,  512,  512, 1'b1, 4'b0000, 5, 1'b0};

    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge aclk);
    areset_n = 1'b1;

    // Frame-length table: each start closes the previous frame and opens the next.
    step(1, 0, 0);
    step(0, 0, 0);
    chk("open_idx", int'(channel_index), 0);
    for (int v = 0; v < 5; v++) begin
      send_chans(vecs[v].n_chan);
      chk("pre_close_idx", int'(channel_index), vecs[v].exp_idx);
      step(1, 0, 0);
      chk("close_done",  int'(frame_done), 1);
      chk("close_last",  int'(last_channel_count), vecs[v].exp_last);
      chk("close_ok",    int'(frame_ok), int'(vecs[v].exp_ok));
      chk("close_flags", int'(error_flags), int'(vecs[v].exp_flags));
      chk("close_fc",    int'(frame_count), vecs[v].exp_fc);
      chk("close_idx",   int'(channel_index), 0);
      step(0, 0, 0);
      chk("done_pulse", int'(frame_done), 0);
      chk("flags_sticky", int'(error_flags), int'(vecs[v].exp_flags));
      if (vecs[v].clr_after) begin
        step(0, 0, 1);
        chk("clear_flags", int'(error_flags), 0);
        chk("clear_fc",    int'(frame_count), vecs[v].exp_fc);
        chk("clear_last",  int'(last_channel_count), vecs[v].exp_last);
      end
    end

    // Start and channel edge together after a full frame.
    send_chans(512);
    step(1, 1, 0);
    chk("same_done", int'(frame_done), 1);
    chk("same_last", int'(last_channel_count), 512);
    chk("same_ok",   int'(frame_ok), 1);
    chk("same_idx",  int'(channel_index), 1);
    step(0, 0, 0);

    // Timeout: close frame, clear, three channels, then silence.
    step(1, 0, 0);
    step(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      if (i < 2) step(0, 0, 0);
    end
    for (int k = 1; k <= TMO; k++) begin
      step(0, 0, 0);
      chk("tmo_no_done", int'(frame_done), 0);
      if (k == TMO - 1) chk("tmo_not_yet", int'(error_flags[3]), 0);
    end
    chk("tmo_flag", int'(error_flags), 4'b1000);
    chk("tmo_idx",  int'(channel_index), 0);
    send_chans(2);
    chk("idle_ignores_chan", int'(channel_index), 0);

    // Start+channel in IDLE, then a same-cycle error beats clear_errors.
    step(1, 1, 0);
    chk("idle_same_idx", int'(channel_index), 1);
    step(0, 0, 0);
    step(1, 0, 1);
    chk("clear_vs_new", int'(error_flags), 4'b0001);
    step(0, 0, 1);

    // Randomized traffic with periodic long silences.
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 599) begin
        repeat (TMO + 20) step(0, 0, 0);
      end else begin
        step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
      end
    end

    // Asynchronous reset mid-frame, then a fresh frame.
    step(1, 0, 0);
    step(0, 0, 0);
    send_chans(5);
    areset_n = 1'b0;
    #2;
    chk_all_zero("async_reset");
    model_reset();
    #2;
    areset_n = 1'b1;
    step(0, 0, 0);
    step(1, 0, 0);
    chk("fresh_idx", int'(channel_index), 0);
    chk("fresh_fc",  int'(frame_count), 0);
    send_chans(2);
    chk("fresh_count", int'(channel_index), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
